// File: rtl/keypad_multitap.sv
// 4x4 matrix keypad scanner with press/release debounce and phone-style
// multi-tap letter entry ('*' commits, '#' submits the word, 'D' clears).
module keypad_multitap #(
  parameter int SCAN_DIV    = 10000,
  parameter int DEBOUNCE    = 50000,
  parameter int TAP_TIMEOUT = 10000000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       word_submit,
  output logic [7:0] preview,
  output logic       pending,
  output logic       error
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TAP_TIMEOUT + 1);

  typedef enum logic [1:0] {S_SCAN, S_PRESS_DB, S_HELD, S_RELEASE_DB} state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_meta, row_s, row_cap;
  logic [SW-1:0]   scan_cnt;
  logic [DW-1:0]   db_cnt;
  logic [TW-1:0]   tap_cnt;
  logic [1:0]      quiet_cols, tap_idx, tap_next, r_idx, c_idx;
  logic            armed, chain_live, scan_freeze, scan_step, db_done;
  logic            db_clr, db_inc, cap_row, key_evt, is_letter, same_chain;
  logic [7:0]      key_ch, pend_key;

  function automatic logic [7:0] key_char(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return "1";  4'h1: return "2";  4'h2: return "3";  4'h3: return "A";
      4'h4: return "4";  4'h5: return "5";  4'h6: return "6";  4'h7: return "B";
      4'h8: return "7";  4'h9: return "8";  4'hA: return "9";  4'hB: return "C";
      4'hC: return "*";  4'hD: return "0";  4'hE: return "#";  default: return "D";
    endcase
  endfunction

  function automatic logic [7:0] group_base(input logic [7:0] ch);
    case (ch)
      "2": return "A";  "3": return "D";  "4": return "G";  "5": return "J";
      "6": return "M";  "7": return "P";  "8": return "T";  "9": return "W";
      default: return 8'h00;
    endcase
  endfunction

  // NOTE: sequential state always uses non-blocking assignment so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_meta <= '0;
      row_s    <= '0;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

  assign scan_freeze = (row_s != 4'b0000) || (state_q == S_RELEASE_DB);
  assign scan_step   = !scan_freeze && (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      scan_cnt <= '0;
      col      <= 4'b1000;
    end else if (!scan_freeze) begin
      if (scan_step) begin
        scan_cnt <= '0;
        col      <= {col[0], col[3:1]};
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // A key held through reset must not fire: events stay blocked until one
  // full column rotation has seen an all-quiet row.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      quiet_cols <= '0;
      armed      <= 1'b0;
    end else if (row_s != 4'b0000) begin
      quiet_cols <= '0;
    end else if (scan_step && !armed) begin
      if (quiet_cols == 2'd3) armed <= 1'b1;
      else                    quiet_cols <= quiet_cols + 1'b1;
    end
  end

  assign db_done = (db_cnt == DW'(DEBOUNCE - 1));

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    db_clr  = 1'b0;
    db_inc  = 1'b0;
    cap_row = 1'b0;
    key_evt = 1'b0;
    case (state_q)
      S_SCAN: if (row_s != 4'b0000) begin
        state_d = S_PRESS_DB;
        db_clr  = 1'b1;
        cap_row = 1'b1;
      end
      S_PRESS_DB:
        if (row_s != row_cap) state_d = S_SCAN;
        else if (db_done) begin
          state_d = S_HELD;
          key_evt = armed && $onehot(row_cap);
        end else db_inc = 1'b1;
      S_HELD: if (row_s == 4'b0000) begin
        state_d = S_RELEASE_DB;
        db_clr  = 1'b1;
      end
      S_RELEASE_DB:
        if (row_s != 4'b0000) state_d = S_HELD;
        else if (db_done)     state_d = S_SCAN;
        else                  db_inc  = 1'b1;
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_SCAN;
      db_cnt  <= '0;
      row_cap <= '0;
    end else begin
      state_q <= state_d;
      if (db_clr)      db_cnt <= '0;
      else if (db_inc) db_cnt <= db_cnt + 1'b1;
      if (cap_row)     row_cap <= row_s;
    end
  end

  always_comb begin
    case (row_cap)
      4'b1000: r_idx = 2'd0;
      4'b0100: r_idx = 2'd1;
      4'b0010: r_idx = 2'd2;
      default: r_idx = 2'd3;
    endcase
    case (col)
      4'b1000: c_idx = 2'd0;
      4'b0100: c_idx = 2'd1;
      4'b0010: c_idx = 2'd2;
      default: c_idx = 2'd3;
    endcase
    key_ch     = key_char(r_idx, c_idx);
    is_letter  = (key_ch >= "2") && (key_ch <= "9");
    same_chain = pending && chain_live && (key_ch == pend_key);
    if (!same_chain)                                           tap_next = 2'd0;
    else if (tap_idx == ((key_ch == "7" || key_ch == "9") ? 2'd3 : 2'd2)) tap_next = 2'd0;
    else                                                       tap_next = tap_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      letter       <= '0;
      letter_valid <= 1'b0;
      word_submit  <= 1'b0;
      error        <= 1'b0;
      preview      <= '0;
      pending      <= 1'b0;
      pend_key     <= '0;
      tap_idx      <= '0;
      chain_live   <= 1'b0;
      tap_cnt      <= '0;
    end else begin
      letter_valid <= 1'b0;
      word_submit  <= 1'b0;
      error        <= 1'b0;
      if (chain_live) begin
        if (tap_cnt == TW'(TAP_TIMEOUT - 1)) chain_live <= 1'b0;
        else                                 tap_cnt    <= tap_cnt + 1'b1;
      end
      // Event handling sits after the timer so a new tap wins over expiry.
      if (key_evt) begin
        if (is_letter) begin
          pending    <= 1'b1;
          pend_key   <= key_ch;
          tap_idx    <= tap_next;
          preview    <= group_base(key_ch) + {6'd0, tap_next};
          chain_live <= 1'b1;
          tap_cnt    <= '0;
        end else if (key_ch == "*") begin
          if (pending) begin
            letter       <= preview;
            letter_valid <= 1'b1;
            pending      <= 1'b0;
            preview      <= '0;
          end else begin
            error <= 1'b1;
          end
        end else if (key_ch == "#") begin
          word_submit <= 1'b1;
          pending     <= 1'b0;
          preview     <= '0;
        end else if (key_ch == "D") begin
          pending <= 1'b0;
          preview <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_multitap.sv
// Randomised bench for keypad_multitap: a simulated key matrix driven by the
// scan columns, checked press-by-press against a letter-group model.
module tb_keypad_multitap;

  localparam int SCAN_DIV    = 4;
  localparam int DEBOUNCE    = 8;
  localparam int TAP_TIMEOUT = 200;
  localparam int HOLD        = 40;

  logic       tb_clk = 1'b0;
  logic       nRst;
  logic [3:0] row, col;
  logic [7:0] letter, preview;
  logic       letter_valid, word_submit, pending, error;
  logic [15:0] keys_down;

  keypad_multitap #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .TAP_TIMEOUT(TAP_TIMEOUT)
  ) dut (
    .clk(tb_clk), .nRst(nRst), .row(row), .col(col),
    .letter(letter), .letter_valid(letter_valid), .word_submit(word_submit),
    .preview(preview), .pending(pending), .error(error)
  );

  always #5 tb_clk = ~tb_clk;

  // Physical matrix: a pressed key shorts its row to its column's drive.
  always_comb begin
    row = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && col[3-c]) row[3-r] = 1'b1;
  end

  int n_checks = 0, n_pass = 0;
  int n_lv, n_ws, n_err;
  int cyc = 0;
  logic [7:0] prev_letter, prev_preview;

  string keymap = "123A456B789C*0#D";
  string groups [8] = '{"ABC", "DEF", "GHI", "JKL", "MNO", "PQRS", "TUV", "WXYZ"};

  // Model state: what the user has typed so far, in letter terms.
  logic [7:0] m_letter, m_preview;
  logic       m_pending;
  byte        m_key;
  int         m_idx;
  int         last_letter_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge tb_clk) cyc <= cyc + 1;

  // Every-cycle invariants plus pulse accounting for the press-level checks.
  always @(negedge tb_clk) begin
    if (nRst !== 1'b1) begin
      prev_letter  = 8'h00;
      prev_preview = 8'h00;
    end else begin
      check("pulse_exclusive", $onehot0({letter_valid, word_submit, error}), 1);
      check("preview_vs_pending", (preview != 8'h00), pending);
      check("col_onehot", $onehot(col), 1);
      if (letter_valid) begin
        n_lv++;
        check("commit_takes_preview", letter, prev_preview);
      end else begin
        check("letter_stable", letter, prev_letter);
      end
      if (word_submit) n_ws++;
      if (error)       n_err++;
      prev_letter  = letter;
      prev_preview = preview;
    end
  end

  task automatic model_reset();
    m_letter = 8'h00; m_preview = 8'h00; m_pending = 1'b0;
    m_key = 0; m_idx = 0; last_letter_cyc = -100000;
  endtask

  task automatic model_key(input byte ch, output int e_lv, output int e_ws, output int e_err);
    string grp;
    bit    alive;
    e_lv = 0; e_ws = 0; e_err = 0;
    if (ch >= "2" && ch <= "9") begin
      grp   = groups[ch - "2"];
      alive = m_pending && (m_key == ch) && ((cyc - last_letter_cyc) <= TAP_TIMEOUT);
      m_idx = alive ? (m_idx + 1) % grp.len() : 0;
      m_key = ch;
      m_pending = 1'b1;
      m_preview = grp[m_idx];
      last_letter_cyc = cyc;
    end else if (ch == "*") begin
      if (m_pending) begin
        m_letter = m_preview; e_lv = 1;
        m_pending = 1'b0; m_preview = 8'h00;
      end else e_err = 1;
    end else if (ch == "#") begin
      e_ws = 1; m_pending = 1'b0; m_preview = 8'h00;
    end else if (ch == "D") begin
      m_pending = 1'b0; m_preview = 8'h00;
    end
  endtask

  task automatic compare_outputs(input string tag, input int e_lv, input int e_ws, input int e_err);
    check({tag, "_lv_count"}, n_lv, e_lv);
    check({tag, "_ws_count"}, n_ws, e_ws);
    check({tag, "_err_count"}, n_err, e_err);
    check({tag, "_letter"}, letter, m_letter);
    check({tag, "_preview"}, preview, m_preview);
    check({tag, "_pending"}, pending, m_pending);
  endtask

  task automatic press(input int r, input int c, input int gap, input string tag);
    byte ch;
    int  e_lv, e_ws, e_err;
    ch = keymap[r*4+c];
    // Keep letter presses clear of the chain-timeout boundary so the
    // expected outcome does not depend on exact scan phase.
    if (ch >= "2" && ch <= "9")
      while ((cyc - last_letter_cyc) >= 140 && (cyc - last_letter_cyc) < 270) @(posedge tb_clk);
    model_key(ch, e_lv, e_ws, e_err);
    n_lv = 0; n_ws = 0; n_err = 0;
    keys_down[r*4+c] = 1'b1;
    repeat (HOLD) @(posedge tb_clk);
    keys_down = '0;
    repeat (40 + gap) @(posedge tb_clk);
    @(negedge tb_clk);
    compare_outputs(tag, e_lv, e_ws, e_err);
  endtask

  task automatic no_event_window(input string tag);
    repeat (40) @(posedge tb_clk);
    @(negedge tb_clk);
    compare_outputs(tag, 0, 0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRst = 1'b0;
    keys_down = '0;
    model_reset();
    repeat (3) @(posedge tb_clk);
    #1;
    check("reset_col", col, 4'b1000);
    check("reset_letter", letter, 8'h00);
    check("reset_preview", preview, 8'h00);
    check("reset_flags", {letter_valid, word_submit, error, pending}, 4'b0000);
    @(negedge tb_clk) nRst = 1'b1;
    repeat (40) @(posedge tb_clk);

    // T1: '2' then '*'
    press(0, 1, 0, "t1_tap2");
    check("t1_preview_A", preview, 8'h41);
    press(3, 0, 0, "t1_commit");
    check("t1_letter_A", letter, 8'h41);
    check("t1_pending_clear", pending, 0);

    // T2: '3' twice then '*'
    press(0, 2, 0, "t2_tap1");
    check("t2_preview_D", preview, 8'h44);
    press(0, 2, 0, "t2_tap2");
    check("t2_preview_E", preview, 8'h45);
    press(3, 0, 0, "t2_commit");
    check("t2_letter_E", letter, 8'h45);

    // T3: group wrap at 3 ('5') and 4 ('7')
    for (int i = 0; i < 3; i++) press(1, 1, 0, "t3_tap5");
    check("t3_preview_L", preview, 8'h4C);
    press(1, 1, 0, "t3_wrap5");
    check("t3_preview_J", preview, 8'h4A);
    for (int i = 0; i < 4; i++) press(2, 0, 0, "t3_tap7");
    check("t3_preview_S", preview, 8'h53);
    press(2, 0, 0, "t3_wrap7");
    check("t3_preview_P", preview, 8'h50);

    // T4: chain expiry keeps the letter but restarts the index
    press(0, 2, 250, "t4_tap");
    press(0, 2, 0, "t4_after_idle");
    check("t4_preview_D", preview, 8'h44);
    press(3, 0, 0, "t4_commit");
    check("t4_letter_D", letter, 8'h44);

    // T5: bounce and multi-key presses must not disturb a pending 'G'
    press(1, 0, 0, "t5_tap4");
    for (int i = 0; i < 10; i++) begin
      keys_down[1] = ~keys_down[1];
      repeat (3) @(posedge tb_clk);
    end
    keys_down = '0;
    no_event_window("t5_bounce");
    keys_down[1] = 1'b1;
    keys_down[5] = 1'b1;
    repeat (HOLD) @(posedge tb_clk);
    keys_down = '0;
    no_event_window("t5_multikey");
    check("t5_preview_G", preview, 8'h47);

    // T6: '#' submits and discards, '*' with nothing pending errors
    press(3, 2, 0, "t6_submit");
    check("t6_ws_pulse", n_ws, 1);
    press(3, 0, 0, "t6_error");
    check("t6_err_pulse", n_err, 1);
    press(0, 3, 0, "t6_keyA_noop");

    // Random key sequence
    for (int i = 0; i < 40; i++)
      press($urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 1) == 1) ? $urandom_range(250, 300) : $urandom_range(0, 20),
            "rand");

    // Reset during a 'D' press
    press(0, 1, 0, "rst_setup");
    keys_down[15] = 1'b1;
    repeat (12) @(posedge tb_clk);
    #2 nRst = 1'b0;
    #1;
    check("midrst_col", col, 4'b1000);
    check("midrst_letter", letter, 8'h00);
    check("midrst_preview", preview, 8'h00);
    check("midrst_flags", {letter_valid, word_submit, error, pending}, 4'b0000);
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk) nRst = 1'b1;
    model_reset();
    repeat (60) @(posedge tb_clk);
    keys_down = '0;
    no_event_window("after_rst_D");

    // A letter key held through reset must not register until released
    keys_down[1] = 1'b1;
    repeat (30) @(posedge tb_clk);
    #2 nRst = 1'b0;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk) nRst = 1'b1;
    model_reset();
    repeat (80) @(posedge tb_clk);
    @(negedge tb_clk);
    check("held_through_rst_pending", pending, 0);
    check("held_through_rst_preview", preview, 8'h00);
    keys_down = '0;
    repeat (40) @(posedge tb_clk);
    press(0, 1, 0, "post_rst_tap2");
    check("post_rst_preview_A", preview, 8'h41);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
